// File: rtl/dispense_if.sv
// Vend-side signal bundle between the upstream coin FSM/dispenser hardware
// and the dispense controller.
interface dispense_if;
  logic       soda;
  logic [2:0] change;
  logic       vend_done;
  logic       vend_motor;
  logic       coin_eject;
  logic       busy;
  logic [3:0] pending;
  logic       overflow;
  logic       vend_fault;

  modport master (
    output soda, change, vend_done,
    input  vend_motor, coin_eject, busy, pending, overflow, vend_fault
  );

  modport slave (
    input  soda, change, vend_done,
    output vend_motor, coin_eject, busy, pending, overflow, vend_fault
  );
endinterface

// File: rtl/dispense_ctrl.sv
// Queues vend requests with their owed change, runs the dispense motor with a
// timeout, then pulses the nickel-eject solenoid once per nickel owed.
module dispense_ctrl #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned EJECT_HIGH   = 4,
  parameter int unsigned EJECT_GAP    = 4,
  parameter int unsigned VEND_TIMEOUT = 255
) (
  input logic       clk,
  input logic       rst,
  dispense_if.slave dif
);

  localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TW     = $clog2(VEND_TIMEOUT + 1);
  localparam int unsigned EJ_MAX = (EJECT_HIGH > EJECT_GAP) ? EJECT_HIGH : EJECT_GAP;
  localparam int unsigned CW     = $clog2(EJ_MAX + 1);

  typedef enum logic [1:0] {IDLE, VEND, EJECT_ON, EJECT_OFF} state_e;

  state_e        state_q;
  logic [2:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [3:0]    count_q;
  logic [3:0]    count_d;
  logic          overflow_q;
  logic [2:0]    cur_change_q;
  logic [TW-1:0] tmo_cnt_q;
  logic [CW-1:0] ej_cnt_q;
  logic          vend_motor_q;
  logic          coin_eject_q;
  logic          vend_fault_q;

  logic pop_c;
  logic full_c;
  logic push_ok_c;
  logic drop_c;
  logic tmo_hit_c;

  // A same-edge pop frees the slot, so a push into a full queue still lands.
  assign pop_c     = (state_q == IDLE) && (count_q != 4'd0);
  assign full_c    = (count_q == 4'(DEPTH));
  assign push_ok_c = dif.soda && (!full_c || pop_c);
  assign drop_c    = dif.soda && full_c && !pop_c;
  assign tmo_hit_c = (tmo_cnt_q == TW'(VEND_TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (push_ok_c && !pop_c) begin
      count_d = count_q + 4'd1;
    end else if (pop_c && !push_ok_c) begin
      count_d = count_q - 4'd1;
    end
  end

  // Request queue bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (drop_c) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok_c) mem_q[wr_ptr_q] <= dif.change;
  end

  // Dispense/eject sequencer; motor and solenoid registers follow the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_change_q <= '0;
      tmo_cnt_q    <= '0;
      ej_cnt_q     <= '0;
      vend_motor_q <= 1'b0;
      coin_eject_q <= 1'b0;
      vend_fault_q <= 1'b0;
    end else begin
      vend_fault_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop_c) begin
            cur_change_q <= mem_q[rd_ptr_q];
            tmo_cnt_q    <= '0;
            vend_motor_q <= 1'b1;
            state_q      <= VEND;
          end
        end
        VEND: begin
          tmo_cnt_q <= tmo_cnt_q + TW'(1);
          if (dif.vend_done || tmo_hit_c) begin
            vend_motor_q <= 1'b0;
            vend_fault_q <= !dif.vend_done;
            ej_cnt_q     <= '0;
            if (cur_change_q != 3'd0) begin
              coin_eject_q <= 1'b1;
              state_q      <= EJECT_ON;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        EJECT_ON: begin
          if (ej_cnt_q == CW'(EJECT_HIGH - 1)) begin
            ej_cnt_q     <= '0;
            coin_eject_q <= 1'b0;
            cur_change_q <= cur_change_q - 3'd1;
            state_q      <= EJECT_OFF;
          end else begin
            ej_cnt_q <= ej_cnt_q + CW'(1);
          end
        end
        EJECT_OFF: begin
          if (ej_cnt_q == CW'(EJECT_GAP - 1)) begin
            ej_cnt_q <= '0;
            if (cur_change_q != 3'd0) begin
              coin_eject_q <= 1'b1;
              state_q      <= EJECT_ON;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            ej_cnt_q <= ej_cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dif.vend_motor = vend_motor_q;
  assign dif.coin_eject = coin_eject_q;
  assign dif.vend_fault = vend_fault_q;
  assign dif.overflow   = overflow_q;
  assign dif.pending    = count_q;
  assign dif.busy       = (state_q != IDLE) || (count_q != 4'd0);

endmodule
